pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Prioritised hazard/sequencing controller for the 5-stage pipeline: latch enables,
// bubble injection, PC write enable, halt drain and stall/redirect performance counters.
module pipeline_ctrl #(
   parameter int DRAIN_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dREN_mem,
   input  logic             dWEN_mem,
   input  logic             halt_mem,
   input  logic             idex_MemRead,
   input  logic [4:0]       idex_rd,
   input  logic [4:0]       ifid_rs,
   input  logic [4:0]       ifid_rt,
   input  logic             branch_taken_ex,
   input  logic             jump_id,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halt_out,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   state_t     state, state_nxt;
   logic [3:0] drain_cnt, drain_cnt_nxt;
   logic       halt_r;
   logic       dstall, lu, stall_evt, flush_evt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign dstall   = (dREN_mem | dWEN_mem) & ~dhit;
   assign lu       = idex_MemRead & (idex_rd != 5'd0) &
                     ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));
   assign halt_out = halt_r;

   always_comb begin
      pc_en         = 1'b1;
      ifid_en       = 1'b1;
      idex_en       = 1'b1;
      exmem_en      = 1'b1;
      memwb_en      = 1'b1;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      exmem_flush   = 1'b0;
      memwb_flush   = 1'b0;
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      flush_evt     = 1'b0;
      case (state)
         RUN: begin
            if (dstall) begin
               pc_en       = 1'b0;
               ifid_en     = 1'b0;
               idex_en     = 1'b0;
               exmem_en    = 1'b0;
               memwb_flush = 1'b1;
            end else if (halt_mem) begin
               // MEM_WB captures the halt while everything younger is squashed
               pc_en         = 1'b0;
               ifid_flush    = 1'b1;
               idex_flush    = 1'b1;
               exmem_flush   = 1'b1;
               state_nxt     = DRAIN;
               drain_cnt_nxt = 4'(DRAIN_CYCLES);
            end else if (branch_taken_ex) begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               flush_evt  = 1'b1;
            end else if (jump_id) begin
               ifid_flush = 1'b1;
               flush_evt  = 1'b1;
            end else if (lu) begin
               pc_en      = 1'b0;
               ifid_en    = 1'b0;
               idex_flush = 1'b1;
            end else if (!ihit) begin
               pc_en      = 1'b0;
               ifid_flush = 1'b1;
            end
         end
         DRAIN: begin
            pc_en         = 1'b0;
            ifid_en       = 1'b0;
            idex_en       = 1'b0;
            exmem_en      = 1'b0;
            memwb_flush   = 1'b1;
            drain_cnt_nxt = drain_cnt - 4'd1;
            if (drain_cnt <= 4'd1) state_nxt = HALTED;
         end
         HALTED: begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
         end
         default: state_nxt = RUN;
      endcase
   end

   assign stall_evt = (state == RUN) & ~pc_en;

   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state     <= RUN;
         drain_cnt <= 4'd0;
         halt_r    <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         halt_r    <= halt_r | (state_nxt == HALTED);
         if (stall_evt) stall_cnt <= sat_inc(stall_cnt);
         if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
      end
   end

   // Undefined hazard inputs while running mean a broken upstream model
   always_ff @(posedge CLK) begin
      if (nRST && state == RUN)
         assert (!$isunknown({ihit, dhit, dREN_mem, dWEN_mem, halt_mem, idex_MemRead,
                              idex_rd, ifid_rs, ifid_rt, branch_taken_ex, jump_id}));
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: the driver queues hand-computed expectations,
// a monitor pops and compares them once per cycle before the active edge.
module tb_pipeline_ctrl;

   localparam logic [8:0] RUNDEF = 9'b1_1111_0000;
   localparam logic [8:0] DSTALL = 9'b0_0001_0001;
   localparam logic [8:0] HALT   = 9'b0_1111_1110;
   localparam logic [8:0] BRANCH = 9'b1_1111_1100;
   localparam logic [8:0] JUMP   = 9'b1_1111_1000;
   localparam logic [8:0] LU     = 9'b0_0111_0100;
   localparam logic [8:0] IMISS  = 9'b0_1111_1000;
   localparam logic [8:0] DRAIN  = 9'b0_0001_0001;
   localparam logic [8:0] HALTED = 9'b0_0000_0000;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       ihit = 1'b1, dhit = 1'b0, dREN_mem = 1'b0, dWEN_mem = 1'b0, halt_mem = 1'b0;
   logic       idex_MemRead = 1'b0, branch_taken_ex = 1'b0, jump_id = 1'b0;
   logic [4:0] idex_rd = 5'd0, ifid_rs = 5'd0, ifid_rt = 5'd0;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, halt_out;
   logic [3:0] stall_cnt, flush_cnt;
   logic [8:0] outv;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string      nm;
      logic [8:0] v;
      logic       h;
      logic [3:0] s;
      logic [3:0] f;
   } exp_t;
   exp_t q[$];

   pipeline_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_mem(dREN_mem),
      .dWEN_mem(dWEN_mem), .halt_mem(halt_mem), .idex_MemRead(idex_MemRead),
      .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
      .branch_taken_ex(branch_taken_ex), .jump_id(jump_id), .pc_en(pc_en),
      .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .memwb_flush(memwb_flush), .halt_out(halt_out), .stall_cnt(stall_cnt),
      .flush_cnt(flush_cnt)
   );

   assign outv = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush};

   always #5 CLK = ~CLK;

   task automatic step(input logic rn, input logic ih, input logic dh, input logic ren,
                       input logic wen, input logic hm, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt, input logic br,
                       input logic jp, input logic [8:0] ev, input logic eh,
                       input logic [3:0] es, input logic [3:0] ef, input string nm);
      exp_t e;
      @(negedge CLK);
      nRST = rn; ihit = ih; dhit = dh; dREN_mem = ren; dWEN_mem = wen; halt_mem = hm;
      idex_MemRead = mr; idex_rd = rd; ifid_rs = rs; ifid_rt = rt;
      branch_taken_ex = br; jump_id = jp;
      e.nm = nm; e.v = ev; e.h = eh; e.s = es; e.f = ef;
      q.push_back(e);
   endtask

   task automatic idle(input logic rn, input logic [8:0] ev, input logic eh,
                       input logic [3:0] es, input logic [3:0] ef, input string nm);
      step(rn, 1,0,0,0,0, 0,5'd0,5'd0,5'd0, 0,0, ev, eh, es, ef, nm);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK);
         #3;
         if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (outv !== e.v) begin
               failures++;
               $display("FAIL %s ctrl: got %b want %b", e.nm, outv, e.v);
            end
            checks++;
            if (halt_out !== e.h) begin
               failures++;
               $display("FAIL %s halt_out: got %b want %b", e.nm, halt_out, e.h);
            end
            checks++;
            if (stall_cnt !== e.s) begin
               failures++;
               $display("FAIL %s stall_cnt: got %0d want %0d", e.nm, stall_cnt, e.s);
            end
            checks++;
            if (flush_cnt !== e.f) begin
               failures++;
               $display("FAIL %s flush_cnt: got %0d want %0d", e.nm, flush_cnt, e.f);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      idle(0, RUNDEF, 0, 0, 0, "reset");
      idle(1, RUNDEF, 0, 0, 0, "run_default");
      // load-use hazards
      step(1, 1,0,0,0,0, 1,5'd5,5'd5,5'd0, 0,0, LU, 0, 0, 0, "lu_rs");
      idle(1, RUNDEF, 0, 1, 0, "lu_one_bubble");
      step(1, 1,0,0,0,0, 1,5'd0,5'd0,5'd0, 0,0, RUNDEF, 0, 1, 0, "lu_rd0");
      step(1, 1,0,0,0,0, 1,5'd7,5'd3,5'd7, 0,0, LU, 0, 1, 0, "lu_rt");
      step(1, 1,0,0,0,0, 1,5'd7,5'd3,5'd4, 0,0, RUNDEF, 0, 2, 0, "lu_nomatch");
      // dcache miss, last miss cycle also carries a malformed halt
      step(1, 1,0,1,0,0, 0,5'd0,5'd0,5'd0, 0,0, DSTALL, 0, 2, 0, "dmiss1");
      step(1, 1,0,1,0,0, 0,5'd0,5'd0,5'd0, 0,0, DSTALL, 0, 3, 0, "dmiss2");
      step(1, 1,0,0,1,0, 0,5'd0,5'd0,5'd0, 0,0, DSTALL, 0, 4, 0, "dmiss_store");
      step(1, 1,0,1,0,1, 0,5'd0,5'd0,5'd0, 0,0, DSTALL, 0, 5, 0, "dmiss_halt");
      step(1, 1,1,1,0,0, 0,5'd0,5'd0,5'd0, 0,0, RUNDEF, 0, 6, 0, "dhit");
      // redirects
      step(1, 0,0,0,0,0, 0,5'd0,5'd0,5'd0, 1,0, BRANCH, 0, 6, 0, "br_imiss");
      idle(1, RUNDEF, 0, 6, 1, "after_br");
      step(1, 1,0,0,0,0, 1,5'd5,5'd5,5'd0, 1,0, BRANCH, 0, 6, 1, "br_lu");
      step(1, 0,0,0,0,0, 0,5'd0,5'd0,5'd0, 0,1, JUMP, 0, 6, 2, "jmp_imiss");
      step(1, 0,0,0,0,0, 0,5'd0,5'd0,5'd0, 0,0, IMISS, 0, 6, 3, "imiss");
      step(1, 1,0,0,0,0, 1,5'd9,5'd0,5'd9, 0,1, JUMP, 0, 7, 3, "jmp_lu");
      step(1, 1,0,0,0,0, 0,5'd0,5'd0,5'd0, 1,1, BRANCH, 0, 7, 4, "br_jmp");
      step(1, 1,0,0,0,1, 0,5'd0,5'd0,5'd0, 1,0, HALT, 0, 7, 5, "halt_br");
      // drain (2 cycles) then halted, inputs ignored
      step(1, 0,0,1,0,0, 1,5'd5,5'd5,5'd0, 1,1, DRAIN, 0, 8, 5, "drain1");
      step(1, 0,0,0,1,1, 0,5'd0,5'd0,5'd0, 1,0, DRAIN, 0, 8, 5, "drain2");
      for (int i = 0; i < 12; i++)
         step(1, logic'(i % 2 == 0), 0,0,0, logic'(i % 4 == 1), 0,5'd0,5'd0,5'd0,
              logic'(i % 2), logic'(i % 3 == 0), HALTED, 1, 8, 5, "halted");
      // async reset mid-drain
      idle(0, RUNDEF, 0, 0, 0, "reset2");
      idle(1, RUNDEF, 0, 0, 0, "run2");
      step(1, 1,0,0,0,1, 0,5'd0,5'd0,5'd0, 0,0, HALT, 0, 0, 0, "halt2");
      idle(1, DRAIN, 0, 1, 0, "drain_b");
      idle(0, RUNDEF, 0, 0, 0, "reset_in_drain");
      idle(1, RUNDEF, 0, 0, 0, "run_after_reset");
      step(1, 0,0,0,0,0, 0,5'd0,5'd0,5'd0, 0,0, IMISS, 0, 0, 0, "imiss_after_reset");
      // stall counter saturation
      for (int i = 1; i < 21; i++)
         step(1, 0,0,0,0,0, 0,5'd0,5'd0,5'd0, 0,0, IMISS, 0,
              (i > 15) ? 4'd15 : 4'(i), 0, "sat");
      idle(1, RUNDEF, 0, 15, 0, "sat_hold");
      for (int i = 0; i < 6 && q.size() != 0; i++) @(negedge CLK);
      #5;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain_queue: got %0d pending want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
